// File: rtl/spi_mem_pkg.sv
// Shared command codes, address width and FSM encoding for the SPI memory responder.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam int         SPI_ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    IGNORE  = 3'd5
  } state_t;

endpackage

// File: rtl/spi_mem_responder_if.sv
// SPI link bundle between the memory controller (master) and the RAM responder (slave).
interface spi_mem_responder_if;

  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic busy;

  modport master (output sclk, cs_n, mosi, input miso, miso_oe, busy);
  modport slave  (input sclk, cs_n, mosi, output miso, miso_oe, busy);

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, with one-clk rise/fall pulses.
module spi_edge_sync #(
  parameter int   SYNC_FF = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_FF-1:0] r_sync;
  logic               r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_FF{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_FF-2:0], i_d};
      r_prev <= r_sync[SYNC_FF-1];
    end
  end

  assign o_q    = r_sync[SYNC_FF-1];
  assign o_rise =  o_q & ~r_prev;
  assign o_fall = ~o_q &  r_prev;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 byte-addressed RAM target (0x03 read, 0x02 write, 24-bit address, bursts).
// Optional backdoor preload port enabled by defining SPI_MEM_LOAD_PORT_EN.
module spi_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int SYNC_FF = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_mem_responder_if.slave  spi
`ifdef SPI_MEM_LOAD_PORT_EN
  ,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [7:0]          ld_data,
  output logic [7:0]          rd_data
`endif
);

  import spi_mem_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t              r_state, w_nxt;
  logic [4:0]          r_cnt;
  logic [6:0]          r_rx;
  logic [7:0]          r_tx;
  logic [ADDR_W-2:0]   r_addr_sh;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_miso;
  logic                r_is_rd;
  logic [SYNC_FF-1:0]  r_mosi_sync;
  logic [7:0]          r_mem [DEPTH];

  logic                w_sclk_unused, w_sclk_rise, w_sclk_fall;
  logic                w_cs_n_s, w_cs_rise, w_cs_fall;
  logic                w_mosi_s, w_rise, w_fall;
  logic [7:0]          w_rx_next;
  logic [ADDR_W-1:0]   w_addr_next, w_rd_idx;
  logic [7:0]          w_mem_rd;
  logic                w_spi_we, w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [7:0]          w_mem_wdata;

  spi_edge_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .i_d(spi.sclk),
    .o_q(w_sclk_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_edge_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .i_d(spi.cs_n),
    .o_q(w_cs_n_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // Same depth as the edge synchronizers so mosi is aligned with the rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_FF-2:0], spi.mosi};
  end

  assign w_mosi_s    = r_mosi_sync[SYNC_FF-1];
  assign w_rise      = w_sclk_rise & ~w_cs_n_s;
  assign w_fall      = w_sclk_fall & ~w_cs_n_s;
  assign w_rx_next   = {r_rx, w_mosi_s};
  assign w_addr_next = {r_addr_sh, w_mosi_s};
  assign w_rd_idx    = (r_state == ADDR) ? w_addr_next : r_addr + ADDR_W'(1);
  assign w_mem_rd    = r_mem[w_rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_spi_we = 1'b0;
    case (r_state)
      IDLE:    if (w_cs_fall) w_nxt = CMD;
      CMD:     if (w_rise && r_cnt == 5'd7)
                 w_nxt = (w_rx_next == CMD_READ || w_rx_next == CMD_WRITE) ? ADDR : IGNORE;
      ADDR:    if (w_rise && r_cnt == 5'(SPI_ADDR_BITS - 1))
                 w_nxt = r_is_rd ? RD_DATA : WR_DATA;
      WR_DATA: w_spi_we = w_rise && (r_cnt == 5'd7);
      default: ;
    endcase
    // Deselect wins over everything, including a coincident last write bit.
    if (w_cs_rise) begin
      w_nxt    = IDLE;
      w_spi_we = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_addr_sh <= '0;
      r_addr    <= '0;
      r_miso    <= 1'b0;
      r_is_rd   <= 1'b0;
    end else if (r_state == IDLE || w_cs_n_s) begin
      r_cnt  <= '0;
      r_miso <= 1'b0;
    end else begin
      case (r_state)
        CMD: if (w_rise) begin
          r_rx  <= w_rx_next[6:0];
          r_cnt <= (r_cnt == 5'd7) ? 5'd0 : r_cnt + 5'd1;
          if (r_cnt == 5'd7) r_is_rd <= (w_rx_next == CMD_READ);
        end
        ADDR: if (w_rise) begin
          r_addr_sh <= w_addr_next[ADDR_W-2:0];
          if (r_cnt == 5'(SPI_ADDR_BITS - 1)) begin
            r_cnt  <= '0;
            r_addr <= w_addr_next;
            r_tx   <= w_mem_rd;
            r_miso <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        RD_DATA: if (w_fall) begin
          r_miso <= r_tx[7];
          if (r_cnt == 5'd7) begin
            r_cnt  <= '0;
            r_addr <= r_addr + ADDR_W'(1);
            r_tx   <= w_mem_rd;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            r_tx  <= {r_tx[6:0], 1'b0};
          end
        end
        WR_DATA: if (w_rise) begin
          r_rx <= w_rx_next[6:0];
          if (r_cnt == 5'd7) begin
            r_cnt  <= '0;
            r_addr <= r_addr + ADDR_W'(1);
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_mem_we    = w_spi_we;
    w_mem_waddr = r_addr;
    w_mem_wdata = w_rx_next;
`ifdef SPI_MEM_LOAD_PORT_EN
    if (ld_we && r_state == IDLE) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = ld_addr;
      w_mem_wdata = ld_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

`ifdef SPI_MEM_LOAD_PORT_EN
  assign rd_data = r_mem[ld_addr];
`endif

  assign spi.miso    = (r_state == RD_DATA) ? r_miso : 1'b0;
  assign spi.miso_oe = ~w_cs_n_s;
  assign spi.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: table of SPI transactions plus corner-case sequences.
module tb_spi_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_mem_responder_if spi ();

`ifdef SPI_MEM_LOAD_PORT_EN
  logic       ld_we;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] rd_data;
`endif

  spi_mem_responder #(.ADDR_W(8), .SYNC_FF(2)) dut (
    .clk(clk),
    .rst(rst),
    .spi(spi)
`ifdef SPI_MEM_LOAD_PORT_EN
    ,
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .rd_data(rd_data)
`endif
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          n;
    logic [31:0] data;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi.mosi = tx[7-i];
      half();
      spi.sclk = 1'b1;
      rx = {rx[6:0], spi.miso};
      half();
      spi.sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi.cs_n = 1'b0;
    half();
  endtask

  task automatic cs_end();
    half();
    spi.cs_n = 1'b1;
    half();
    half();
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    spi_bits(cmd, 8, rx);
    spi_bits(addr[23:16], 8, rx);
    spi_bits(addr[15:8], 8, rx);
    spi_bits(addr[7:0], 8, rx);
  endtask

  task automatic read_burst(input string name, input int n);
    logic [7:0] rx;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, rx);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: scoreboard empty, got %0h", name, rx);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", name, i), {24'h0, rx}, {24'h0, e});
      end
    end
  endtask

  task automatic spi_read(input string name, input logic [23:0] addr, input int n, input logic [31:0] exp);
    for (int b = 0; b < n; b++) exp_q.push_back(exp[31-8*b -: 8]);
    cs_begin();
    send_hdr(8'h03, addr);
    read_burst(name, n);
    cs_end();
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: run did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx, rx1, rx2;

    vecs[0] = '{8'h02, 24'h000010, 2, 32'hAA55_0000};
    vecs[1] = '{8'h02, 24'h000012, 2, 32'h3CC3_0000};
    vecs[2] = '{8'h03, 24'h000010, 4, 32'hAA55_3CC3};
    vecs[3] = '{8'h02, 24'hAB00FF, 2, 32'h1122_0000};
    vecs[4] = '{8'h03, 24'h0000FF, 2, 32'h1122_0000};
    vecs[5] = '{8'h03, 24'h123400, 1, 32'h2200_0000};
    vecs[6] = '{8'h02, 24'h000020, 1, 32'h5A00_0000};
    vecs[7] = '{8'h03, 24'h000020, 1, 32'h5A00_0000};

    rst      = 1'b1;
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
`ifdef SPI_MEM_LOAD_PORT_EN
    ld_we   = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
`endif
    repeat (4) @(negedge clk);
    check("reset_miso", {31'h0, spi.miso}, 32'h0);
    check("reset_oe",   {31'h0, spi.miso_oe}, 32'h0);
    check("reset_busy", {31'h0, spi.busy}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", {31'h0, spi.busy}, 32'h0);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].cmd == 8'h03) begin
        spi_read($sformatf("vec%0d_rd", v), vecs[v].addr, vecs[v].n, vecs[v].data);
      end else begin
        cs_begin();
        check($sformatf("vec%0d_oe", v), {31'h0, spi.miso_oe}, 32'h1);
        send_hdr(vecs[v].cmd, vecs[v].addr);
        check($sformatf("vec%0d_busy", v), {31'h0, spi.busy}, 32'h1);
        for (int b = 0; b < vecs[v].n; b++) spi_bits(vecs[v].data[31-8*b -: 8], 8, rx);
        cs_end();
      end
      check($sformatf("vec%0d_idle", v), {31'h0, spi.busy}, 32'h0);
    end

    // Unknown command: miso stays low, memory untouched.
    cs_begin();
    spi_bits(8'h9F, 8, rx);
    spi_bits(8'hFF, 8, rx1);
    spi_bits(8'hFF, 8, rx2);
    check("ign_miso", {16'h0, rx1, rx2}, 32'h0);
    check("ign_busy", {31'h0, spi.busy}, 32'h1);
    cs_end();
    check("ign_idle", {31'h0, spi.busy}, 32'h0);
    spi_read("ign_after", 24'h000010, 2, 32'hAA55_0000);

    // Aborted write after 5 data bits must not reach memory.
    cs_begin();
    send_hdr(8'h02, 24'h000020);
    spi_bits(8'hFF, 5, rx);
    cs_end();
    check("abort_idle", {31'h0, spi.busy}, 32'h0);
    spi_read("abort_rd", 24'h000020, 1, 32'h5A00_0000);

    // Reset in the middle of a read burst.
    cs_begin();
    send_hdr(8'h03, 24'h000010);
    spi_bits(8'h00, 3, rx);
    check("rst_partial", {24'h0, rx}, 32'h05);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_miso", {31'h0, spi.miso}, 32'h0);
    check("rst_oe",   {31'h0, spi.miso_oe}, 32'h0);
    check("rst_busy", {31'h0, spi.busy}, 32'h0);
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    half();
    spi_read("rst_after", 24'h000011, 2, 32'h553C_0000);

`ifdef SPI_MEM_LOAD_PORT_EN
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 8'h40; ld_data = 8'hC3;
    @(negedge clk);
    ld_addr = 8'h41; ld_data = 8'h66;
    @(negedge clk);
    ld_we = 1'b0; ld_addr = 8'h40;
    #1;
    check("ld_rd_data", {24'h0, rd_data}, 32'hC3);
    spi_read("ld_spi_rd", 24'h000040, 1, 32'hC300_0000);
    cs_begin();
    send_hdr(8'h03, 24'h000000);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 8'h41; ld_data = 8'h99;
    @(negedge clk);
    ld_we = 1'b0;
    #1;
    check("ld_busy_drop", {24'h0, rd_data}, 32'h66);
    cs_end();
`endif

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
